xyz_lane_dispatch: RTL
======================

# xyz_lane_dispatch

Upstream dispatcher for the three-lane XYZ design (`mkDesign_11`). It accepts a single valid/ready request stream tagged with a lane number. For each request it drives that lane's `start` method, then its `check` method, and captures the check return value. Captured values go back out on one result stream through round-robin arbitration. It replaces the hand-tied stimulus currently used on the XYZ ports.

## Interface
- `W`, default 5: operand/result width; must match the XYZ lane width.
- `CLK`  in  1: clock, rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: request present.
- `in_ready`  out  1: request accepted when `in_valid && in_ready`.
- `in_lane`  in  2: target lane, 0..2; 3 is illegal.
- `in_a`, `in_b`, `in_d`  in  W each: start operands and check operand.
- `xyz_start_a`, `xyz_start_b`  out  3*W: per-lane start operands; lane i at bits [i*W +: W].
- `en_xyz_start`  out  3: per-lane start enable.
- `rdy_xyz_start`  in  3: per-lane start ready.
- `xyz_check_d`  out  3*W: per-lane check operand.
- `en_xyz_check`  out  3: per-lane check enable.
- `rdy_xyz_check`  in  3: per-lane check ready.
- `xyz_check`  in  3*W: per-lane check return value.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: result consumed when `out_valid && out_ready`.
- `out_lane`  out  2: lane of the result.
- `out_chk`  out  W: check value.
- `err_cnt`  out  8: count of illegal-lane requests; saturates at 255.

## Operation
- Each lane has its own FSM with states IDLE, START, CHECK, plus operand registers a/b/d and a result slot (valid bit plus W-bit data).
  - **IDLE:** when a request is accepted for this lane, latch a/b/d and go to START.
  - **START:** `en_xyz_start[i] = rdy_xyz_start[i]`, driven combinationally from the state. When enabled, go to CHECK.
  - **CHECK:** `en_xyz_check[i] = rdy_xyz_check[i] && (!slot_valid || slot draining this cycle)`. When enabled, capture `xyz_check[i]` into the slot and go to IDLE.
- Start and check operand outputs always reflect the latched registers. They are 0 after reset.
- `in_ready = (in_lane == 3) || (lane[in_lane] is IDLE)`.
  - Accepting a lane-3 request drops it and increments `err_cnt`.
  - `in_ready` depends combinationally on `in_lane` only, never on `out_ready`.
- Output arbiter:
  - Round-robin over lanes whose slot is valid.
  - Search starts at `last+1` (mod 3), where `last` is the pointer register.
  - `last` updates only on an output handshake.
  - `out_lane`/`out_chk` come from the granted slot. `out_valid` = any slot valid.
  - The grant stays stable while `out_valid && !out_ready`.
- Results are in order per lane. Lanes operate independently and concurrently.

## Timing
- Reset values:
  - All FSMs in IDLE; all slots empty.
  - `en_*` = 0, `out_valid` = 0, `out_lane` = 0, `out_chk` = 0, `err_cnt` = 0.
  - `last` = 2, so lane 0 wins first.
  - `in_ready` = 1 for any lane.
- Minimum latency with all RDY high and `out_ready` high:
  - Accept at cycle t.
  - `en_xyz_start` at t+1.
  - `en_xyz_check` at t+2.
  - `out_valid` at t+3.
  - The lane returns to IDLE at t+3, so its next accept is at t+3 and throughput is one request per lane per 3 cycles.
- RDY low holds the FSM in its state with `en` low. There is no timeout.
- A full slot plus `out_ready` low stalls that lane in CHECK. Other lanes are unaffected.
- Slot capture and drain in the same cycle is allowed: the slot stays valid with the new data.
- `RST` asserted mid-operation abandons in-flight requests next cycle. No `en` pulse may follow the reset cycle.

## Structure
- Package `xyz_pkg` holds:
  - `XYZ_W` = 5 and `XYZ_NLANE` = 3;
  - the lane-state enum `{IDLE, START, CHECK}`;
  - the `lane_t` 2-bit typedef.
- Sub-module `xyz_lane_ctl` contains one lane's FSM, operand registers and result slot. It is instantiated 3 times.
- The top level holds the input demux, the `err_cnt` counter and the round-robin arbiter.

## Test plan
- Reset, then send lane 0 with a=3, b=4, d=5, all RDY=1, `xyz_check[0]`=9 → `en_xyz_start[0]` at t+1 with `xyz_start_a[0:4]`=3; `en_xyz_check[0]` at t+2; `out_valid` at t+3 with lane 0, chk 9.
- Requests to lanes 0, 1, 2 on consecutive cycles with `out_ready`=0 until all three slots are full → then `out_ready`=1 drains them in order 0, 1, 2. A second lane-0 request is refused (`in_ready`=0) while lane 0 is busy.
- Hold `rdy_xyz_start[1]`=0 for 5 cycles → lane 1 stays in START with no `en` pulse. Lanes 0 and 2 complete normally.
- Send 300 lane-3 requests → `in_ready`=1 throughout, `err_cnt`=255, no `en` pulses, `out_valid`=0.
- Assert `RST` on the cycle `en_xyz_start[2]` is high → the next cycle has all `en` at 0, `out_valid`=0, and `in_ready`=1.
- Lane 0 slot full and held, then a new lane-0 check completes in the same cycle as the drain → the output shows the old value, then the new value, with no loss.

Source files
------------

// File: rtl/xyz_pkg.sv
// Shared types for the XYZ lane dispatcher.
// Lane count, default width and lane FSM encoding.
package xyz_pkg;

    localparam int XYZ_W     = 5;
    localparam int XYZ_NLANE = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        CHECK
    } lane_st_e;

    typedef logic [1:0] lane_t;

    function automatic lane_t lane_inc(input lane_t l);
        return (l == 2'd2) ? 2'd0 : l + 2'd1;
    endfunction

endpackage

// File: rtl/xyz_lane_ctl.sv
// One XYZ lane: start/check sequencer, operand
// registers and a single-entry result slot.
module xyz_lane_ctl
    import xyz_pkg::*;
#(
    parameter int W = XYZ_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         acc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] d,
    input  logic         rdy_start,
    input  logic         rdy_check,
    input  logic [W-1:0] chk,
    input  logic         drain,
    output logic         idle,
    output logic         en_start,
    output logic         en_check,
    output logic [W-1:0] start_a,
    output logic [W-1:0] start_b,
    output logic [W-1:0] check_d,
    output logic         slot_valid,
    output logic [W-1:0] slot_data
);

    lane_st_e st;

    assign idle     = (st == IDLE);
    assign en_start = (st == START) && rdy_start;
    // a full slot may still accept when it empties this same cycle
    assign en_check = (st == CHECK) && rdy_check
                    && (!slot_valid || drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            start_a <= '0;
            start_b <= '0;
            check_d <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (acc) begin
                        start_a <= a;
                        start_b <= b;
                        check_d <= d;
                        st      <= START;
                    end
                end
                START: begin
                    if (en_start) st <= CHECK;
                end
                CHECK: begin
                    if (en_check) st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid <= 1'b0;
            slot_data  <= '0;
        end else if (en_check) begin
            slot_valid <= 1'b1;
            slot_data  <= chk;
        end else if (drain) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/xyz_lane_dispatch.sv
// Request demux onto three XYZ lanes, illegal-lane
// counter and round-robin merge of check results.
module xyz_lane_dispatch
    import xyz_pkg::*;
#(
    parameter int W = XYZ_W
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     in_lane,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [W-1:0]   in_d,
    output logic [3*W-1:0] xyz_start_a,
    output logic [3*W-1:0] xyz_start_b,
    output logic [2:0]     en_xyz_start,
    input  logic [2:0]     rdy_xyz_start,
    output logic [3*W-1:0] xyz_check_d,
    output logic [2:0]     en_xyz_check,
    input  logic [2:0]     rdy_xyz_check,
    input  logic [3*W-1:0] xyz_check,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     out_lane,
    output logic [W-1:0]   out_chk,
    output logic [7:0]     err_cnt
);

    logic [2:0]   idle;
    logic [2:0]   acc;
    logic [2:0]   drain;
    logic [2:0]   sv;
    logic [W-1:0] sd [XYZ_NLANE];

    lane_t last;
    lane_t gnt;
    lane_t lk_lane;
    lane_t p1;
    lane_t p2;
    lane_t p3;
    logic  lk;
    logic  hs;

    always_comb begin
        in_ready = 1'b1;
        case (in_lane)
            2'd0:    in_ready = idle[0];
            2'd1:    in_ready = idle[1];
            2'd2:    in_ready = idle[2];
            default: in_ready = 1'b1;
        endcase
    end

    for (genvar i = 0; i < XYZ_NLANE; i++) begin : g_lane
        assign acc[i]   = in_valid && in_ready
                       && (in_lane == lane_t'(i));
        assign drain[i] = hs && (gnt == lane_t'(i));

        xyz_lane_ctl #(.W(W)) u_lane (
            .clk       (CLK),
            .rst       (RST),
            .acc       (acc[i]),
            .a         (in_a),
            .b         (in_b),
            .d         (in_d),
            .rdy_start (rdy_xyz_start[i]),
            .rdy_check (rdy_xyz_check[i]),
            .chk       (xyz_check[i*W +: W]),
            .drain     (drain[i]),
            .idle      (idle[i]),
            .en_start  (en_xyz_start[i]),
            .en_check  (en_xyz_check[i]),
            .start_a   (xyz_start_a[i*W +: W]),
            .start_b   (xyz_start_b[i*W +: W]),
            .check_d   (xyz_check_d[i*W +: W]),
            .slot_valid(sv[i]),
            .slot_data (sd[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt <= '0;
        end else if (in_valid && in_lane == 2'd3
                     && err_cnt != 8'hff) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    // a stalled grant is pinned so a newly filled
    // higher-priority slot cannot steal the output
    always_comb begin
        p1  = lane_inc(last);
        p2  = lane_inc(p1);
        p3  = lane_inc(p2);
        gnt = p3;
        if (lk)          gnt = lk_lane;
        else if (sv[p1]) gnt = p1;
        else if (sv[p2]) gnt = p2;
    end

    assign out_valid = |sv;
    assign hs        = out_valid && out_ready;
    assign out_lane  = out_valid ? gnt : 2'd0;

    always_comb begin
        out_chk = '0;
        if (out_valid) begin
            case (gnt)
                2'd0:    out_chk = sd[0];
                2'd1:    out_chk = sd[1];
                default: out_chk = sd[2];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last    <= 2'd2;
            lk      <= 1'b0;
            lk_lane <= 2'd0;
        end else begin
            if (hs) last <= gnt;
            lk      <= out_valid && !out_ready;
            lk_lane <= gnt;
        end
    end

endmodule
